dmem_waitstate: RTL and testbench



---
 rtl/dmem_waitstate.sv | 208 ++++++++++++++++++++
 tb/tb_dmem_waitstate.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_waitstate.sv
`default_nettype none
// ============================================================================
// Module   : dmem_waitstate
// Purpose  : Wait-state data memory with a valid/ready handshake, supporting
//            byte/half/word little-endian accesses and error reporting.
//            Optional macro DMEM_SIGNED_LOAD_EN adds req_signed (LDRSB/LDRSH).
// Revision : 1.0 - initial release
// ============================================================================
module dmem_waitstate #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
`ifdef DMEM_SIGNED_LOAD_EN
    input  logic              req_signed,
`endif
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int         c_idx_w   = $clog2(DEPTH);
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [31:0]       mem [0:DEPTH-1];

    logic              w_accept;
    logic              w_commit;
    logic              w_acc_we;
    logic [1:0]        w_acc_size;
    logic [ADDR_W-1:0] w_acc_addr;
    logic [31:0]       w_acc_wdata;
    logic              w_oor;
    logic              w_acc_err;
    logic              w_sext;
    logic [c_idx_w-1:0] w_idx;
    logic [31:0]       w_shift;
    logic [31:0]       w_load;
    logic [31:0]       w_wdata_rep;
    logic [3:0]        w_be;
    logic              w_write;

    assign w_accept = (state_q == c_st_idle) && req_valid;

    // With zero wait states the access commits on the accept edge, so it must
    // be taken from the live request rather than the latched copy.
    assign w_commit = (w_accept && (WAIT_CYCLES == 0)) ||
                      ((state_q == c_st_busy) && (cnt_q == 4'd1));

    assign w_acc_we    = (state_q == c_st_idle) ? req_we    : we_q;
    assign w_acc_size  = (state_q == c_st_idle) ? req_size  : size_q;
    assign w_acc_addr  = (state_q == c_st_idle) ? req_addr  : addr_q;
    assign w_acc_wdata = (state_q == c_st_idle) ? req_wdata : wdata_q;

`ifdef DMEM_SIGNED_LOAD_EN
    logic signed_q, signed_d;
    assign w_sext = (state_q == c_st_idle) ? req_signed : signed_q;
`else
    assign w_sext = 1'b0;
`endif

    generate
        if (ADDR_W > c_idx_w + 2) begin : g_range_chk
            assign w_oor = |w_acc_addr[ADDR_W-1:c_idx_w+2];
        end else begin : g_range_full
            assign w_oor = 1'b0;
        end
    endgenerate

    assign w_acc_err = (w_acc_size == 2'b11) ||
                       ((w_acc_size == 2'b01) && w_acc_addr[0]) ||
                       ((w_acc_size == 2'b10) && (w_acc_addr[1:0] != 2'b00)) ||
                       w_oor;

    assign w_idx   = w_acc_addr[c_idx_w+1:2];
    assign w_shift = mem[w_idx] >> {w_acc_addr[1:0], 3'b000};
    assign w_write = w_commit && w_acc_we && !w_acc_err && !reset;

    always_comb begin
        w_load      = w_shift;
        w_wdata_rep = w_acc_wdata;
        w_be        = 4'b0000;
        case (w_acc_size)
            2'b00: begin
                w_load      = {{24{w_sext & w_shift[7]}}, w_shift[7:0]};
                w_wdata_rep = {4{w_acc_wdata[7:0]}};
                w_be        = 4'b0001 << w_acc_addr[1:0];
            end
            2'b01: begin
                w_load      = {{16{w_sext & w_shift[15]}}, w_shift[15:0]};
                w_wdata_rep = {2{w_acc_wdata[15:0]}};
                w_be        = w_acc_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_write) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) mem[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= c_st_idle;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
`ifdef DMEM_SIGNED_LOAD_EN
            signed_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
`ifdef DMEM_SIGNED_LOAD_EN
            signed_q <= signed_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            c_st_idle: begin
                if (req_valid) begin
                    state_d = (WAIT_CYCLES == 0) ? c_st_resp : c_st_busy;
                    cnt_d   = 4'(WAIT_CYCLES);
                end
            end
            c_st_busy: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = c_st_resp;
            end
            c_st_resp: begin
                if (rsp_ready) state_d = c_st_idle;
            end
            default: state_d = c_st_idle;
        endcase
    end

    always_comb begin
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef DMEM_SIGNED_LOAD_EN
        signed_d = signed_q;
        if (w_accept) signed_d = req_signed;
`endif
        if (w_accept) begin
            we_d    = req_we;
            size_d  = req_size;
            addr_d  = req_addr;
            wdata_d = req_wdata;
        end
        if (w_commit) begin
            rdata_d = (w_acc_err || w_acc_we) ? 32'd0 : w_load;
            err_d   = w_acc_err;
        end
    end

    always_comb begin
        req_ready = (state_q == c_st_idle);
        rsp_valid = (state_q == c_st_resp);
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_waitstate.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_waitstate
// Purpose  : Self-checking bench for dmem_waitstate (WAIT_CYCLES=2 and =0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_waitstate;

    localparam int W     = 2;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we, rsp_ready;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        req_signed;

    logic        req_valid_z, req_we_z, rsp_ready_z;
    logic [1:0]  req_size_z;
    logic [31:0] req_addr_z, req_wdata_z;
    logic        req_ready_z, rsp_valid_z, rsp_err_z;
    logic [31:0] rsp_rdata_z;
    logic        req_signed_z;

    always #5 clk = ~clk;

    dmem_waitstate #(.DEPTH(DEPTH), .WAIT_CYCLES(W), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef DMEM_SIGNED_LOAD_EN
        .req_signed(req_signed),
`endif
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_waitstate #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .ADDR_W(32)) dut_z (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_z), .req_ready(req_ready_z), .req_we(req_we_z),
        .req_size(req_size_z), .req_addr(req_addr_z), .req_wdata(req_wdata_z),
`ifdef DMEM_SIGNED_LOAD_EN
        .req_signed(req_signed_z),
`endif
        .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z),
        .rsp_rdata(rsp_rdata_z), .rsp_err(rsp_err_z)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte-addressed memory, response scheduled W edges after accept.
    logic [7:0]  mbytes [0:4*DEPTH-1];
    int          phase  = 0;
    int          edge_n = 0;
    int          due    = 0;
    logic        m_we, m_sgn;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;

    function automatic logic is_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
               (a >= 32'(4 * DEPTH));
    endfunction

    task automatic model_commit();
        int n;
        n         = 1 << m_size;
        exp_err   = is_err(m_size, m_addr);
        exp_rdata = 32'd0;
        if (!exp_err) begin
            if (m_we) begin
                for (int i = 0; i < n; i++) mbytes[m_addr + 32'(i)] = m_wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) exp_rdata[8*i +: 8] = mbytes[m_addr + 32'(i)];
                if (m_sgn && n < 4 && exp_rdata[8*n-1])
                    exp_rdata = exp_rdata | ~((32'd1 << (8*n)) - 32'd1);
            end
        end
    endtask

    always @(posedge clk) begin
        edge_n++;
        if (reset) begin
            phase = 0;
        end else begin
            case (phase)
                0: if (req_valid) begin
                    m_we = req_we; m_size = req_size; m_addr = req_addr; m_wdata = req_wdata;
`ifdef DMEM_SIGNED_LOAD_EN
                    m_sgn = req_signed;
`else
                    m_sgn = 1'b0;
`endif
                    due   = edge_n + W;
                    phase = 1;
                end
                1: if (edge_n == due) begin
                    model_commit();
                    phase = 2;
                end
                default: if (rsp_ready) phase = 0;
            endcase
        end
    end

    always begin
        @(posedge clk);
        #2;
        if (chk_en && !reset) begin
            chk("m_req_ready", 32'(req_ready), 32'(phase == 0));
            chk("m_rsp_valid", 32'(rsp_valid), 32'(phase == 2));
            if (phase == 2) begin
                chk("m_rsp_rdata", rsp_rdata, exp_rdata);
                chk("m_rsp_err", 32'(rsp_err), 32'(exp_err));
            end
        end
    end

    task automatic xact(input logic we, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic sg, input int hold,
                        output logic [31:0] rd, output logic er, output int lat);
        int t;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
        req_signed = sg;
        t = 0;
        while (!req_ready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) begin checks++; errors++; $display("FAIL accept_timeout actual=busy expected=ready"); end
        @(negedge clk);
        req_valid = 1'($urandom_range(0, 1)); req_we = 1'($urandom);
        req_size = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
        lat = 1;
        while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
        if (lat >= 50) begin checks++; errors++; $display("FAIL rsp_timeout actual=none expected=rsp_valid"); end
        for (int i = 0; i < hold; i++) begin
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            @(negedge clk);
        end
        rd = rsp_rdata; er = rsp_err;
        rsp_ready = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic xact_z(input logic we, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input int hold,
                          output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        req_valid_z = 1'b1; req_we_z = we; req_size_z = sz; req_addr_z = a; req_wdata_z = wd;
        @(negedge clk);
        req_valid_z = 1'b0;
        lat = 1;
        while (!rsp_valid_z && lat < 50) begin @(negedge clk); lat++; end
        if (lat >= 50) begin checks++; errors++; $display("FAIL z_rsp_timeout actual=none expected=rsp_valid"); end
        rd = rsp_rdata_z; er = rsp_err_z;
        for (int i = 0; i < hold; i++) begin
            chk("z_hold_req_ready", 32'(req_ready_z), 32'd0);
            chk("z_hold_rdata", rsp_rdata_z, rd);
            chk("z_hold_err", 32'(rsp_err_z), 32'(er));
            @(negedge clk);
        end
        rsp_ready_z = 1'b1;
        @(negedge clk);
        rsp_ready_z = 1'b0;
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [1:0]  sz;
        logic [31:0] a;

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0; req_signed = 1'b0;
        req_valid_z = 1'b0; req_we_z = 1'b0; req_size_z = 2'd0; req_addr_z = 32'd0;
        req_wdata_z = 32'd0; rsp_ready_z = 1'b0; req_signed_z = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b0;
        chk_en = 1'b1;

        for (int i = 0; i < DEPTH; i++) xact(1'b1, 2'd2, 32'(4 * i), 32'hA500_0000 | 32'(i), 1'b0, 0, rd, er, lat);

        xact(1'b1, 2'd2, 32'h64, 32'h0000_0007, 1'b0, 0, rd, er, lat);
        chk("str_latency", 32'(lat), 32'd3);
        chk("str_rdata", rd, 32'd0);
        xact(1'b0, 2'd2, 32'h64, 32'd0, 1'b0, 0, rd, er, lat);
        chk("ldr_latency", 32'(lat), 32'd3);
        chk("ldr_rdata", rd, 32'h0000_0007);
        chk("ldr_err", 32'(er), 32'd0);

        xact(1'b1, 2'd2, 32'h10, 32'h1122_3344, 1'b0, 0, rd, er, lat);
        xact(1'b1, 2'd0, 32'h12, 32'h0000_00AA, 1'b0, 0, rd, er, lat);
        xact(1'b0, 2'd2, 32'h10, 32'd0, 1'b0, 0, rd, er, lat);
        chk("lane_word", rd, 32'h11AA_3344);
        xact(1'b0, 2'd0, 32'h13, 32'd0, 1'b0, 0, rd, er, lat);
        chk("lane_byte", rd, 32'h0000_0011);
        xact(1'b0, 2'd1, 32'h12, 32'd0, 1'b0, 0, rd, er, lat);
        chk("lane_half", rd, 32'h0000_11AA);

        xact(1'b0, 2'd2, 32'h02, 32'd0, 1'b0, 0, rd, er, lat);
        chk("err_word_mis", {rd[30:0], er}, 32'd1);
        xact(1'b0, 2'd1, 32'h01, 32'd0, 1'b0, 0, rd, er, lat);
        chk("err_half_mis", {rd[30:0], er}, 32'd1);
        xact(1'b1, 2'd3, 32'h00, 32'hFFFF_FFFF, 1'b0, 0, rd, er, lat);
        chk("err_size", {rd[30:0], er}, 32'd1);
        xact(1'b1, 2'd2, 32'h100, 32'hFFFF_FFFF, 1'b0, 0, rd, er, lat);
        chk("err_range", {rd[30:0], er}, 32'd1);
        chk("err_range_lat", 32'(lat), 32'd3);
        xact(1'b0, 2'd2, 32'h00, 32'd0, 1'b0, 0, rd, er, lat);
        chk("word0_kept", rd, 32'hA500_0000);
        xact(1'b0, 2'd2, 32'hFC, 32'd0, 1'b0, 0, rd, er, lat);
        chk("last_word", rd, 32'hA500_003F);
        chk("last_word_err", 32'(er), 32'd0);

        xact(1'b0, 2'd2, 32'h10, 32'd0, 1'b0, 5, rd, er, lat);
        chk("hold_rdata", rd, 32'h11AA_3344);
        chk("post_hold_idle", 32'(req_ready), 32'd1);
        chk("post_hold_novalid", 32'(rsp_valid), 32'd0);

        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_rsp_rdata", rsp_rdata, 32'd0);
        chk("abort_rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        xact(1'b0, 2'd2, 32'h20, 32'd0, 1'b0, 0, rd, er, lat);
        chk("abort_no_write", rd, 32'hA500_0008);

`ifdef DMEM_SIGNED_LOAD_EN
        xact(1'b1, 2'd2, 32'h30, 32'h0000_80F0, 1'b0, 0, rd, er, lat);
        xact(1'b0, 2'd0, 32'h30, 32'd0, 1'b1, 0, rd, er, lat);
        chk("ldrsb", rd, 32'hFFFF_FFF0);
        xact(1'b0, 2'd1, 32'h30, 32'd0, 1'b1, 0, rd, er, lat);
        chk("ldrsh", rd, 32'hFFFF_80F0);
        xact(1'b0, 2'd0, 32'h30, 32'd0, 1'b0, 0, rd, er, lat);
        chk("ldrb_unsigned", rd, 32'h0000_00F0);
`endif

        for (int n = 0; n < 200; n++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 4 * DEPTH - 1));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
            if ($urandom_range(0, 15) == 0) a = 32'(4 * DEPTH) + 32'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) a = $urandom;
            xact(1'($urandom), sz, a, $urandom, 1'($urandom), $urandom_range(0, 3), rd, er, lat);
        end

        xact_z(1'b1, 2'd2, 32'h08, 32'h5A5A_1234, 0, rd, er, lat);
        chk("z_str_latency", 32'(lat), 32'd1);
        chk("z_str_err", 32'(er), 32'd0);
        xact_z(1'b0, 2'd2, 32'h08, 32'd0, 5, rd, er, lat);
        chk("z_ldr_latency", 32'(lat), 32'd1);
        chk("z_ldr_rdata", rd, 32'h5A5A_1234);
        chk("z_idle_after", 32'(req_ready_z), 32'd1);
        xact_z(1'b0, 2'd1, 32'h0A, 32'd0, 0, rd, er, lat);
        chk("z_ldrh", rd, 32'h0000_5A5A);
        xact_z(1'b0, 2'd2, 32'h0E, 32'd0, 0, rd, er, lat);
        chk("z_err_mis", {rd[30:0], er}, 32'd1);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
